// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM states.
// The register slave is meant to import this package too.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdAddr = 3'd3,
    StRdData = 3'd4
  } master_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Command-driven single-outstanding AXI4-Lite master; every AXI output is registered.
// A slave that never answers stalls the master forever (no timeout by design).
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRESS-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_write,
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  master_state_e         r_state;
  logic                  r_cmd_ready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDRESS-1:0]    r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_wvalid;
  logic                  r_bready;
  logic [ADDRESS-1:0]    r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_write;

  // Include this cycle's handshake so simultaneous AW/W completion is seen at once.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = r_aw_done | (r_awvalid & M_AWREADY);
  assign w_w_done  = r_w_done  | (r_wvalid  & M_WREADY);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_rsp_write <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          // cmd_ready comes up one cycle after reset release, then stays up while idle.
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_wstrb   <= cmd_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= StWrReq;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= StRdAddr;
            end
          end
        end
        StWrReq: begin
          if (r_awvalid && M_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_WREADY)   r_wvalid  <= 1'b0;
          r_aw_done <= w_aw_done;
          r_w_done  <= w_w_done;
          if (w_aw_done && w_w_done) begin
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= StWrResp;
          end
        end
        StWrResp: begin
          if (M_BVALID && r_bready) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_BRESP;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        StRdAddr: begin
          if (r_arvalid && M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdData;
          end
        end
        StRdData: begin
          if (M_RVALID && r_rready) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_RDATA;
            r_rsp_resp  <= M_RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_aw_done   <= 1'b0;
          r_w_done    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign rsp_write = r_rsp_write;
  assign M_AWADDR  = r_awaddr;
  assign M_AWVALID = r_awvalid;
  assign M_WDATA   = r_wdata;
  assign M_WSTRB   = r_wstrb;
  assign M_WVALID  = r_wvalid;
  assign M_BREADY  = r_bready;
  assign M_ARADDR  = r_araddr;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed and randomized bench for axi4_lite_master; the bench plays the AXI slave
// and keeps a 16-word memory as the reference for read data.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [3:0]  M_WSTRB;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          rsp_pulses = 0;
  int          ar_hs = 0;
  int          exp_rsp = 0;
  int          exp_ar = 0;
  bit          hold_valid = 1'b0;
  logic [31:0] mem [16];

  always @(posedge ACLK) begin
    if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    if (M_ARVALID && M_ARREADY) ar_hs <= ar_hs + 1;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge ACLK);
    check1("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  // Latency counts rising edges from the accepting edge through the completing edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] bresp);
    int lat;
    bit aw_done, w_done;
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(posedge ACLK); lat = 1;
    @(negedge ACLK);
    if (!hold_valid) cmd_valid = 1'b0;
    check1("wr_busy_cmd_ready", cmd_ready, 1'b0);
    check1("wr_prev_rsp_pulse", rsp_valid, 1'b0);
    check32("wr_aw_w_together", {30'd0, M_AWVALID, M_WVALID}, 32'd3);
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      check1("wr_awvalid_level", M_AWVALID, !aw_done);
      check1("wr_wvalid_level", M_WVALID, !w_done);
      if (!aw_done) check32("wr_awaddr_stable", M_AWADDR, addr);
      if (!w_done) begin
        check32("wr_wdata_stable", M_WDATA, data);
        check32("wr_wstrb_stable", {28'd0, M_WSTRB}, {28'd0, strb});
      end
      check1("wr_bready_early", M_BREADY, 1'b0);
      M_AWREADY = !aw_done && c >= aw_dly;
      M_WREADY  = !w_done && c >= w_dly;
      @(posedge ACLK); lat++;
      if (M_AWREADY) aw_done = 1'b1;
      if (M_WREADY) w_done = 1'b1;
      @(negedge ACLK);
      M_AWREADY = 1'b0; M_WREADY = 1'b0;
    end
    check1("wr_aw_w_done", aw_done && w_done, 1'b1);
    check1("wr_awvalid_dropped", M_AWVALID, 1'b0);
    check1("wr_wvalid_dropped", M_WVALID, 1'b0);
    for (int c = 0; c < b_dly; c++) begin
      check1("wr_bready_wait", M_BREADY, 1'b1);
      check1("wr_rsp_early", rsp_valid, 1'b0);
      @(posedge ACLK); lat++;
      @(negedge ACLK);
    end
    check1("wr_bready", M_BREADY, 1'b1);
    M_BVALID = 1'b1; M_BRESP = bresp;
    @(posedge ACLK); lat++;
    @(negedge ACLK);
    M_BVALID = 1'b0; M_BRESP = 2'b00;
    check1("wr_rsp_valid", rsp_valid, 1'b1);
    check32("wr_rsp_resp", {30'd0, rsp_resp}, {30'd0, bresp});
    check1("wr_rsp_write", rsp_write, 1'b1);
    check1("wr_bready_dropped", M_BREADY, 1'b0);
    check1("wr_cmd_ready_back", cmd_ready, 1'b1);
    check32("wr_latency", lat, 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly);
    for (int i = 0; i < 4; i++) if (strb[i]) mem[addr[3:0]][8*i +: 8] = data[8*i +: 8];
    exp_rsp++;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input logic [1:0] rresp);
    int lat;
    logic [31:0] exp_data;
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
    @(posedge ACLK); lat = 1;
    @(negedge ACLK);
    if (!hold_valid) cmd_valid = 1'b0;
    check1("rd_busy_cmd_ready", cmd_ready, 1'b0);
    check1("rd_prev_rsp_pulse", rsp_valid, 1'b0);
    for (int c = 0; c < ar_dly; c++) begin
      check1("rd_arvalid_hold", M_ARVALID, 1'b1);
      check32("rd_araddr_stable", M_ARADDR, addr);
      check1("rd_rready_early", M_RREADY, 1'b0);
      @(posedge ACLK); lat++;
      @(negedge ACLK);
    end
    check1("rd_arvalid", M_ARVALID, 1'b1);
    check32("rd_araddr", M_ARADDR, addr);
    M_ARREADY = 1'b1;
    @(posedge ACLK); lat++;
    @(negedge ACLK);
    M_ARREADY = 1'b0;
    check1("rd_arvalid_dropped", M_ARVALID, 1'b0);
    for (int c = 0; c < r_dly; c++) begin
      check1("rd_rready_wait", M_RREADY, 1'b1);
      @(posedge ACLK); lat++;
      @(negedge ACLK);
    end
    check1("rd_rready", M_RREADY, 1'b1);
    exp_data = mem[addr[3:0]];
    M_RVALID = 1'b1; M_RDATA = exp_data; M_RRESP = rresp;
    @(posedge ACLK); lat++;
    @(negedge ACLK);
    M_RVALID = 1'b0; M_RDATA = $urandom; M_RRESP = 2'b00;
    check1("rd_rsp_valid", rsp_valid, 1'b1);
    check32("rd_rsp_rdata", rsp_rdata, exp_data);
    check32("rd_rsp_resp", {30'd0, rsp_resp}, {30'd0, rresp});
    check1("rd_rsp_write", rsp_write, 1'b0);
    check1("rd_rready_dropped", M_RREADY, 1'b0);
    check1("rd_cmd_ready_back", cmd_ready, 1'b1);
    check32("rd_latency", lat, 3 + ar_dly + r_dly);
    exp_rsp++;
    exp_ar++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    ARESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00;
    repeat (2) @(negedge ACLK);
    check1("rst_cmd_ready", cmd_ready, 1'b0);
    check32("rst_valids", {27'd0, M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}, 32'd0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_awaddr", M_AWADDR, 32'd0);
    check32("rst_wdata", M_WDATA, 32'd0);
    check32("rst_araddr", M_ARADDR, 32'd0);
    check32("rst_rsp_rdata", rsp_rdata, 32'd0);
    check32("rst_rsp_resp_write", {29'd0, rsp_resp, rsp_write}, 32'd0);
    ARESET = 1'b0;

    // Minimum-latency write then read-back.
    do_write(32'h5, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, RESP_OKAY);
    do_read(32'h5, 0, 0, RESP_OKAY);
    // W accepted 4 cycles after AW.
    do_write(32'h6, 32'h1234_5678, 4'hF, 0, 4, 1, RESP_OKAY);
    // Error responses pass through.
    do_read(32'h6, 1, 2, RESP_SLVERR);
    do_write(32'h7, 32'hCAFE_F00D, 4'h5, 2, 0, 0, RESP_DECERR);
    do_read(32'h7, 0, 0, RESP_OKAY);

    // Three back-to-back reads with cmd_valid never dropped.
    hold_valid = 1'b1;
    do_read(32'h1, 0, 0, RESP_OKAY);
    do_read(32'h2, 0, 0, RESP_OKAY);
    do_read(32'h3, 0, 0, RESP_OKAY);
    hold_valid = 1'b0;
    cmd_valid = 1'b0;

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write({28'd0, 4'($urandom_range(0, 15))}, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)));
      else
        do_read({28'd0, 4'($urandom_range(0, 15))}, $urandom_range(0, 3),
                $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a write request.
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9; cmd_wdata = 32'hA5A5_A5A5;
    cmd_wstrb = 4'hF;
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check1("mid_awvalid", M_AWVALID, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    check1("async_awvalid", M_AWVALID, 1'b0);
    check1("async_wvalid", M_WVALID, 1'b0);
    check1("async_cmd_ready", cmd_ready, 1'b0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    wait_cmd_ready();
    check1("post_reset_rsp", rsp_valid, 1'b0);
    do_read(32'h5, 0, 0, RESP_OKAY);

    @(negedge ACLK);
    check32("total_rsp_pulses", rsp_pulses, exp_rsp);
    check32("total_ar_handshakes", ar_hs, exp_ar);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
